// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32-step shift/add multiply and restoring divide
// on operand magnitudes, with sign fix-up and a registered register-file write request.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [4:0]       i_rd_addr,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_wren,
    output logic [4:0]       o_rd_addr,
    output logic [XLEN-1:0]  o_rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    state_t       state_r;
    state_t       state_s;
    logic [5:0]   cnt_r;
    logic [2:0]   funct3_r;
    logic [4:0]   rd_r;
    // Multiply: {high partial sum, multiplier shifting out}. Divide: {remainder, dividend/quotient}.
    logic [63:0]  acc_r;
    logic [31:0]  opa_r;
    logic         neg_q_r;
    logic         neg_r_r;

    logic         accept_s;
    logic         signed_a_s;
    logic         signed_b_s;
    logic         sign_a_s;
    logic         sign_b_s;
    logic [31:0]  mag_a_s;
    logic [31:0]  mag_b_s;
    logic         div_zero_s;
    logic         div_ovf_s;
    logic         special_s;
    logic [32:0]  mul_sum_s;
    logic [63:0]  mul_next_s;
    logic [32:0]  div_trial_s;
    logic [63:0]  div_next_s;
    logic [63:0]  mul_full_s;
    logic [31:0]  quo_s;
    logic [31:0]  rem_s;
    logic [31:0]  result_s;
    logic         ready_next_s;

    assign accept_s = i_valid && o_ready && (state_r == ST_IDLE);

    always_comb begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
        case (i_funct3)
            3'b001: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b1;
            end
            3'b010: signed_a_s = 1'b1;
            3'b100, 3'b110: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b1;
            end
            default: begin
                signed_a_s = 1'b0;
                signed_b_s = 1'b0;
            end
        endcase
    end

    assign sign_a_s   = signed_a_s & i_rs1_data[31];
    assign sign_b_s   = signed_b_s & i_rs2_data[31];
    assign mag_a_s    = cond_neg32(i_rs1_data, sign_a_s);
    assign mag_b_s    = cond_neg32(i_rs2_data, sign_b_s);
    assign div_zero_s = (i_rs2_data == 32'd0);
    assign div_ovf_s  = !i_funct3[0] && (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
    assign special_s  = i_funct3[2] && (div_zero_s || div_ovf_s);

    // One multiplier bit per step; the 33-bit sum keeps the carry out of the high half.
    assign mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opa_r} : 33'd0);
    assign mul_next_s = {mul_sum_s, acc_r[31:1]};

    assign div_trial_s = {acc_r[63:32], acc_r[31]} - {1'b0, opa_r};
    assign div_next_s  = div_trial_s[32] ? {acc_r[62:0], 1'b0}
                                         : {div_trial_s[31:0], acc_r[30:0], 1'b1};

    assign mul_full_s = cond_neg64(acc_r, neg_q_r);
    assign quo_s      = cond_neg32(acc_r[31:0], neg_q_r);
    assign rem_s      = cond_neg32(acc_r[63:32], neg_r_r);

    always_comb begin
        result_s = 32'd0;
        case (funct3_r)
            3'b000:                 result_s = mul_full_s[31:0];
            3'b001, 3'b010, 3'b011: result_s = mul_full_s[63:32];
            3'b100, 3'b101:         result_s = quo_s;
            3'b110, 3'b111:         result_s = rem_s;
            default:                result_s = 32'd0;
        endcase
    end

    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (special_s) begin
                        state_s = ST_DONE;
                    end else if (i_funct3[2]) begin
                        state_s = ST_DIV;
                    end else begin
                        state_s = ST_MUL;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_r == 6'd31) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r    <= 6'd0;
            funct3_r <= 3'd0;
            rd_r     <= 5'd0;
            acc_r    <= 64'd0;
            opa_r    <= 32'd0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        funct3_r <= i_funct3;
                        rd_r     <= i_rd_addr;
                        cnt_r    <= 6'd0;
                        if (special_s) begin
                            // Result is fixed at acceptance; loaded so the normal fix-up passes it through.
                            opa_r   <= 32'd0;
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                            acc_r   <= div_zero_s ? {i_rs1_data, 32'hFFFF_FFFF}
                                                  : {32'd0, 32'h8000_0000};
                        end else if (i_funct3[2]) begin
                            acc_r   <= {32'd0, mag_a_s};
                            opa_r   <= mag_b_s;
                            neg_q_r <= sign_a_s ^ sign_b_s;
                            neg_r_r <= sign_a_s;
                        end else begin
                            acc_r   <= {32'd0, mag_b_s};
                            opa_r   <= mag_a_s;
                            neg_q_r <= sign_a_s ^ sign_b_s;
                            neg_r_r <= 1'b0;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r <= mul_next_s;
                    if (cnt_r != 6'd31) begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                ST_DIV: begin
                    acc_r <= div_next_s;
                    if (cnt_r != 6'd31) begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Ready stays low through the completion cycle so the next op is taken one cycle later.
    assign ready_next_s = (state_s == ST_IDLE) && (state_r != ST_DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ready   <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_rd_wren <= 1'b0;
            o_rd_addr <= 5'd0;
            o_rd_data <= 32'd0;
        end else begin
            o_ready   <= ready_next_s;
            o_busy    <= !ready_next_s;
            o_done    <= (state_r == ST_DONE);
            o_rd_wren <= (state_r == ST_DONE) && (rd_r != 5'd0);
            o_rd_addr <= rd_r;
            o_rd_data <= (state_r == ST_DONE) ? result_s : 32'd0;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: driver pushes model results, a negedge monitor checks
// every completion for data, destination, write enable and exact latency.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [4:0]  i_rd_addr;
    logic        o_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_rd_wren;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;

    always #5 clk = ~clk;

    mdu_iter dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .i_funct3   (i_funct3),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_rd_addr  (i_rd_addr),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_rd_wren  (o_rd_wren),
        .o_rd_addr  (o_rd_addr),
        .o_rd_data  (o_rd_data)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RV32M semantics straight from wide arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb6, ua, ub, p;
        logic signed [31:0] as, bs;
        sa  = {{32{a[31]}}, a};
        sb6 = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        as  = a;
        bs  = b;
        case (f)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sb6; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return as / bs;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return as % bs;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Monitor: pops the scoreboard on every completion and polices idle cycles.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            chk("busy_vs_ready", {31'd0, o_busy}, {31'd0, ~o_ready});
            if (o_done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {31'd0, o_done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rd_data", o_rd_data, e.data);
                    chk("rd_addr", {27'd0, o_rd_addr}, {27'd0, e.rd});
                    chk("rd_wren", {31'd0, o_rd_wren}, {31'd0, (e.rd != 5'd0)});
                    chk("latency", cyc, e.cyc);
                end
            end else begin
                chk("idle_wren", {31'd0, o_rd_wren}, 32'd0);
                chk("idle_data", o_rd_data, 32'd0);
                if (sb.size() > 0 && cyc > sb[0].cyc) begin
                    chk("done_timeout", cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Called just after a rising edge; returns the acceptance edge's cycle number.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit hold, output int acc_cyc);
        exp_t e;
        bit   rdy;
        int   guard;
        i_valid    = 1'b1;
        i_funct3   = f;
        i_rs1_data = a;
        i_rs2_data = b;
        i_rd_addr  = rd;
        guard      = 0;
        acc_cyc    = -1;
        do begin
            rdy = o_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 100);
        if (!rdy) begin
            chk("accept_timeout", {31'd0, rdy}, 32'd1);
            i_valid = 1'b0;
        end else begin
            acc_cyc = cyc;
            e.data  = ref_op(f, a, b);
            e.rd    = rd;
            e.cyc   = cyc + (is_special(f, a, b) ? 1 : 33);
            sb.push_back(e);
            if (!hold) i_valid = 1'b0;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() > 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
        chk({tag, "_busy"},  {31'd0, o_busy},  32'd0);
        chk({tag, "_done"},  {31'd0, o_done},  32'd0);
        chk({tag, "_wren"},  {31'd0, o_rd_wren}, 32'd0);
        chk({tag, "_addr"},  {27'd0, o_rd_addr}, 32'd0);
        chk({tag, "_data"},  o_rd_data, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, e2, ea;
        logic [2:0] f;
        rst        = 1'b0;
        i_valid    = 1'b0;
        i_funct3   = 3'd0;
        i_rs1_data = 32'd0;
        i_rs2_data = 32'd0;
        i_rd_addr  = 5'd0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Multiply corner: all ones.
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0, ea);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, ea);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, ea);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0, ea);
        // Signed and unsigned division.
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0, ea);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0, ea);
        issue(3'd5, 32'd100, 32'd7, 5'd7, 1'b0, ea);
        issue(3'd7, 32'd100, 32'd7, 5'd8, 1'b0, ea);
        // Special cases.
        issue(3'd5, 32'd5, 32'd0, 5'd9, 1'b0, ea);
        issue(3'd7, 32'd5, 32'd0, 5'd10, 1'b0, ea);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, ea);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0, ea);
        drain();

        // rd=0 still completes; stray requests while busy are dropped.
        issue(3'd0, 32'd3, 32'd4, 5'd0, 1'b0, ea);
        run_to(ea + 5);
        i_valid = 1'b1; i_funct3 = 3'd5; i_rs1_data = 32'd77; i_rs2_data = 32'd0; i_rd_addr = 5'd13;
        @(posedge clk);
        #1 i_valid = 1'b0;
        run_to(ea + 20);
        i_valid = 1'b1; i_funct3 = 3'd1; i_rs1_data = 32'h1234_5678;
        @(posedge clk);
        #1 i_valid = 1'b0;
        drain();

        // Reset mid-divide aborts without a write.
        issue(3'd5, 32'hDEAD_BEEF, 32'd3, 5'd14, 1'b0, ea);
        run_to(ea + 10);
        rst = 1'b1;
        #1 check_reset_outputs("midop_reset");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        issue(3'd0, 32'h0001_0000, 32'h0001_0000, 5'd15, 1'b0, ea);
        issue(3'd3, 32'h0001_0000, 32'h0001_0000, 5'd16, 1'b0, ea);
        drain();

        // Back-to-back with valid held high; operand changes after acceptance must not matter.
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 1'b1, e1);
        issue(3'd5, 32'd100, 32'd7, 5'd18, 1'b1, e2);
        chk("b2b_accept_cycle", e2, e1 + 35);
        issue(3'd7, 32'd5, 32'd0, 5'd19, 1'b1, e1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 1'b0, e2);
        chk("b2b_special_accept_cycle", e2, e1 + 3);
        drain();

        for (int n = 0; n < 150; n++) begin
            f = 3'($urandom_range(0, 7));
            issue(f, pick(), pick(), 5'($urandom_range(0, 31)), 1'b0, ea);
        end
        drain();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
